// File: rtl/rr_select_arbiter_pkg.sv
// Shared definitions for the round-robin select arbiter: FSM state encoding
// and a width helper that never returns zero for tiny ranges.
package rr_select_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // $clog2 returns 0 for n<=1 and 1 for n==2; a select bus needs at least one bit
  function automatic int selWidth(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating first-one finder: returns the first set request
// bit when scanning from i_ptr upward, wrapping at N-1 back to 0.
module rr_priority_pick #(
  parameter int N  = 5,
  parameter int SW = 3
) (
  input  logic [N-1:0]  i_req,
  input  logic [SW-1:0] i_ptr,
  output logic [SW-1:0] o_winner,
  output logic          o_any
);

  logic [SW:0] w_sum;

  // Scan offsets from the far end so the closest offset to i_ptr wins last
  always_comb begin
    o_winner = '0;
    o_any    = 1'b0;
    w_sum    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_sum = {1'b0, i_ptr} + (SW + 1)'(k);
      if (w_sum >= (SW + 1)'(N)) begin
        w_sum = w_sum - (SW + 1)'(N);
      end
      if (i_req[w_sum[SW-1:0]]) begin
        o_winner = w_sum[SW-1:0];
        o_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_select_arbiter.sv
// Round-robin arbiter producing a registered select index and one-hot grant
// for a downstream N:1 mux; grants are held until done, request drop or timeout.
module rr_select_arbiter
  import rr_select_arbiter_pkg::*;
#(
  parameter int N        = 5,
  parameter int MAX_HOLD = 16,
  localparam int SW      = selWidth(N)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [N-1:0]  req,
  input  logic          done,
  output logic [SW-1:0] sel,
  output logic [N-1:0]  gnt,
  output logic          grant_valid,
  output logic          timeout
);

  localparam int CW = selWidth(MAX_HOLD + 1);

  state_t        r_state;
  logic [SW-1:0] r_sel;
  logic [N-1:0]  r_gnt;
  logic          r_valid;
  logic          r_timeout;
  logic [SW-1:0] r_ptr;
  logic [CW-1:0] r_cnt;

  state_t        w_nextState;
  logic [SW-1:0] w_nextSel;
  logic [N-1:0]  w_nextGnt;
  logic          w_nextValid;
  logic          w_nextTimeout;
  logic [SW-1:0] w_nextPtr;
  logic [CW-1:0] w_nextCnt;
  logic [SW-1:0] w_winner;
  logic          w_any;
  logic          w_atLimit;
  logic          w_release;

  rr_priority_pick #(
    .N  (N),
    .SW (SW)
  ) u_pick (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  assign w_atLimit = (r_cnt == CW'(MAX_HOLD - 1));
  assign w_release = done || !req[r_sel] || w_atLimit;

  // timeout is registered, so it is raised on the edge that brings the counter
  // to its final value; an earlier release suppresses it
  always_comb begin
    w_nextState   = r_state;
    w_nextSel     = r_sel;
    w_nextGnt     = r_gnt;
    w_nextValid   = r_valid;
    w_nextTimeout = 1'b0;
    w_nextPtr     = r_ptr;
    w_nextCnt     = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_nextState   = BUSY;
          w_nextSel     = w_winner;
          w_nextGnt     = N'(1) << w_winner;
          w_nextValid   = 1'b1;
          w_nextCnt     = '0;
          w_nextTimeout = (MAX_HOLD == 1);
        end
      end
      BUSY: begin
        if (w_release) begin
          w_nextState = IDLE;
          w_nextGnt   = '0;
          w_nextValid = 1'b0;
          w_nextPtr   = (r_sel == SW'(N - 1)) ? '0 : r_sel + 1'b1;
          w_nextCnt   = '0;
        end else begin
          if (r_cnt != CW'(MAX_HOLD)) begin
            w_nextCnt = r_cnt + 1'b1;
          end
          w_nextTimeout = ((r_cnt + 1'b1) == CW'(MAX_HOLD - 1));
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_sel     <= '0;
      r_gnt     <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_ptr     <= '0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_nextState;
      r_sel     <= w_nextSel;
      r_gnt     <= w_nextGnt;
      r_valid   <= w_nextValid;
      r_timeout <= w_nextTimeout;
      r_ptr     <= w_nextPtr;
      r_cnt     <= w_nextCnt;
    end
  end

  assign sel         = r_sel;
  assign gnt         = r_gnt;
  assign grant_valid = r_valid;
  assign timeout     = r_timeout;

endmodule
